// File: rtl/seg_disp_pkg.sv
// Shared constants, types and helpers for the 7-segment scan multiplexer.
package seg_disp_pkg;

    localparam int unsigned DEF_NUM_DIGITS = 4;
    localparam int unsigned IDX_W          = $clog2(DEF_NUM_DIGITS);

    typedef logic [IDX_W-1:0]          digit_idx_t;
    typedef logic [DEF_NUM_DIGITS-1:0] anode_t;

    localparam anode_t ANODE_OFF = '1;

    typedef struct packed {
        logic [4*DEF_NUM_DIGITS-1:0] digits;
        logic [DEF_NUM_DIGITS-1:0]   dots;
        logic [DEF_NUM_DIGITS-1:0]   blank;
    } frame_t;

    // Active-low one-hot anode for the given digit index.
    function automatic anode_t anode_sel(input digit_idx_t idx);
        anode_t a;
        a      = ANODE_OFF;
        a[idx] = 1'b0;
        return a;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Slot prescaler: marks the last cycle of each digit slot and the anodes-off guard window.
module scan_tick_gen #(
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 2000
) (
    input  logic clk,
    input  logic rst_n,
    output logic slot_tick,
    output logic in_guard
);

    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_END = CNT_W'(GUARD_CYCLES);

    logic [CNT_W-1:0] div_cnt_q, div_cnt_d;

    assign slot_tick = (div_cnt_q == CNT_LAST);
    assign in_guard  = (div_cnt_q < GUARD_END);

    always_comb begin
        div_cnt_d = div_cnt_q + 1'b1;
        if (slot_tick) begin
            div_cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q <= '0;
        end else begin
            div_cnt_q <= div_cnt_d;
        end
    end

endmodule

// File: rtl/seg_scan_mux.sv
// Four-digit 7-segment scanner: rotates one active-low anode per slot with a guard gap,
// double-buffered digit data and optional leading-zero suppression.
module seg_scan_mux
    import seg_disp_pkg::*;
#(
    parameter int unsigned NUM_DIGITS   = DEF_NUM_DIGITS,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GUARD_CYCLES = 2000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   dots,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    lz_en,
    output logic [NUM_DIGITS-1:0]   anode_n,
    output logic [3:0]              nibble,
    output logic                    dot_n,
    output logic                    frame_start
);

    localparam digit_idx_t LAST_IDX = digit_idx_t'(NUM_DIGITS - 1);

    logic       slot_tick;
    logic       in_guard;
    logic       frame_wrap;
    digit_idx_t idx_q, idx_d;

    frame_t in_frame;
    frame_t shadow_q, shadow_d;
    frame_t active_q, active_d;

    logic [NUM_DIGITS-1:0] dark;
    logic                  zero_run;

    anode_t     anode_q, anode_d;
    logic [3:0] nibble_q, nibble_d;
    logic       dot_n_q, dot_n_d;
    logic       frame_start_q, frame_start_d;

    scan_tick_gen #(
        .REFRESH_DIV  (REFRESH_DIV),
        .GUARD_CYCLES (GUARD_CYCLES)
    ) u_scan_tick_gen (
        .clk       (clk),
        .rst_n     (rst_n),
        .slot_tick (slot_tick),
        .in_guard  (in_guard)
    );

    assign frame_wrap = slot_tick && (idx_q == LAST_IDX);
    assign in_frame   = '{digits: digits, dots: dots, blank: blank};

    always_comb begin
        idx_d = idx_q;
        if (slot_tick) begin
            idx_d = frame_wrap ? '0 : idx_q + 1'b1;
        end
    end

    // Active only changes when a new frame starts; a coincident load bypasses the shadow.
    always_comb begin
        shadow_d = load ? in_frame : shadow_q;
        active_d = frame_wrap ? shadow_d : active_q;
    end

    // Walk from the most significant digit down while every digit seen so far is a bare zero.
    always_comb begin
        zero_run = lz_en;
        dark     = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            zero_run = zero_run && (active_q.digits[4*i +: 4] == 4'h0) && !active_q.dots[i];
            dark[i]  = active_q.blank[i] || (zero_run && (i != 0));
        end
    end

    always_comb begin
        anode_d       = anode_sel(idx_q);
        if (in_guard || dark[idx_q]) begin
            anode_d = ANODE_OFF;
        end
        nibble_d      = active_q.digits[{idx_q, 2'b00} +: 4];
        dot_n_d       = ~active_q.dots[idx_q];
        frame_start_d = frame_wrap;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q         <= '0;
            shadow_q      <= '0;
            active_q      <= '0;
            anode_q       <= ANODE_OFF;
            nibble_q      <= 4'h0;
            dot_n_q       <= 1'b1;
            frame_start_q <= 1'b0;
        end else begin
            idx_q         <= idx_d;
            shadow_q      <= shadow_d;
            active_q      <= active_d;
            anode_q       <= anode_d;
            nibble_q      <= nibble_d;
            dot_n_q       <= dot_n_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign anode_n     = anode_q;
    assign nibble      = nibble_q;
    assign dot_n       = dot_n_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Randomized and directed bench for seg_scan_mux against a slot-arithmetic reference model.
module tb_seg_scan_mux;

    localparam int unsigned N     = 4;
    localparam int unsigned R     = 8;
    localparam int unsigned G     = 2;
    localparam int unsigned FRAME = N * R;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic        lz_en = 1'b0;
    logic [15:0] digits = '0;
    logic [3:0]  dots   = '0;
    logic [3:0]  blank  = '0;

    logic [3:0]  anode_n;
    logic [3:0]  nibble;
    logic        dot_n;
    logic        frame_start;

    int total = 0;
    int bad   = 0;

    // Model: k counts edges since reset; displayed data plus pending buffer.
    int          k = 0;
    logic [15:0] m_dig, s_dig;
    logic [3:0]  m_dots, s_dots, m_blank, s_blank;
    logic [3:0]  e_anode;
    logic [3:0]  e_nib;
    logic        e_dotn;
    logic        e_fs;

    always #5 clk = ~clk;

    seg_scan_mux #(
        .NUM_DIGITS   (N),
        .REFRESH_DIV  (R),
        .GUARD_CYCLES (G)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load        (load),
        .digits      (digits),
        .dots        (dots),
        .blank       (blank),
        .lz_en       (lz_en),
        .anode_n     (anode_n),
        .nibble      (nibble),
        .dot_n       (dot_n),
        .frame_start (frame_start)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s @%0t: got %0h want %0h", tag, $time, obs, exp);
        end
    endtask

    // Digit is dark if blanked, or (lz on, not digit 0) it and all above are zero with no dots.
    function automatic bit is_dark(input int i);
        if (m_blank[i]) return 1'b1;
        if (!lz_en || i == 0) return 1'b0;
        return ((m_dig >> (4 * i)) == 16'h0) && ((m_dots >> i) == 4'h0);
    endfunction

    task automatic model_edge();
        int cnt;
        int slot;
        if (!rst_n) begin
            k       = 0;
            m_dig   = '0; m_dots = '0; m_blank = '0;
            s_dig   = '0; s_dots = '0; s_blank = '0;
            e_anode = 4'hF;
            e_nib   = 4'h0;
            e_dotn  = 1'b1;
            e_fs    = 1'b0;
        end else begin
            cnt     = k % R;
            slot    = (k / R) % N;
            e_fs    = ((k % FRAME) == FRAME - 1);
            e_nib   = 4'((m_dig >> (4 * slot)) & 16'hF);
            e_dotn  = !m_dots[slot];
            e_anode = (cnt < G || is_dark(slot)) ? 4'hF : (4'hF ^ (4'h1 << slot));
            if (e_fs) begin
                m_dig   = load ? digits : s_dig;
                m_dots  = load ? dots   : s_dots;
                m_blank = load ? blank  : s_blank;
            end
            if (load) begin
                s_dig = digits; s_dots = dots; s_blank = blank;
            end
            k++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        model_edge();
        check("anode_n", 32'(anode_n), 32'(e_anode));
        check("nibble", 32'(nibble), 32'(e_nib));
        check("dot_n", 32'(dot_n), 32'(e_dotn));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("one_anode", 32'($countones(~anode_n) <= 1), 32'd1);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Advance until the next edge is taken from frame position p.
    task automatic wait_pos(input int p);
        for (int i = 0; i < int'(FRAME) && (k % FRAME) != p; i++) step();
    endtask

    task automatic do_load(input logic [15:0] d, input logic [3:0] dt, input logic [3:0] b);
        digits = d; dots = dt; blank = b; load = 1'b1;
        step();
        load = 1'b0;
    endtask

    function automatic logic [15:0] rand_digits();
        logic [15:0] d;
        d = '0;
        for (int i = 0; i < 4; i++) begin
            if ($urandom_range(0, 1) == 1) d[4*i +: 4] = 4'($urandom_range(0, 15));
        end
        return d;
    endfunction

    initial begin
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;

        do_load(16'h1234, 4'b0000, 4'b0000);
        run(2 * FRAME);

        wait_pos(2 * R);
        do_load(16'hABCD, 4'b0000, 4'b0000);
        run(FRAME + R);
        wait_pos(FRAME - 1);
        do_load(16'h5678, 4'b0000, 4'b0000);
        run(FRAME);

        do_load(16'h1234, 4'b0100, 4'b1000);
        run(2 * FRAME);

        lz_en = 1'b1;
        do_load(16'h0070, 4'b0000, 4'b0000);
        run(2 * FRAME);
        do_load(16'h0000, 4'b0000, 4'b0000);
        run(2 * FRAME);
        do_load(16'h0070, 4'b1000, 4'b0000);
        run(2 * FRAME);

        wait_pos(2 * R + 4);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        do_load(16'h9876, 4'b0001, 4'b0000);
        run(2 * FRAME);

        for (int c = 0; c < 1500; c++) begin
            digits = rand_digits();
            dots   = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            blank  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'h0;
            load   = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) lz_en = ~lz_en;
            rst_n  = ($urandom_range(0, 399) != 0);
            step();
        end
        rst_n = 1'b1;
        load  = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
